// File: rtl/ifns_pkg.sv
// ifns_pkg: shared widths, Fibonacci weight table and FSM state type for the
// sequential IFNS encoder.
package ifns_pkg;

    localparam int DATA_W = 20;
    localparam int CODE_W = 29;

    // d29 is weighted F30 rather than following the F(k) pattern of d2..d28.
    localparam logic [DATA_W-1:0] TOP_WEIGHT = 20'd832040;
    localparam logic [4:0]        TOP_IDX    = 5'd29;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TOP  = 3'd1,
        STEP = 3'd2,
        LAST = 3'd3,
        DONE = 3'd4
    } state_e;

    function automatic logic [DATA_W-1:0] fib(input logic [4:0] k);
        logic [DATA_W-1:0] f;
        case (k)
            5'd1:    f = 20'd1;
            5'd2:    f = 20'd1;
            5'd3:    f = 20'd2;
            5'd4:    f = 20'd3;
            5'd5:    f = 20'd5;
            5'd6:    f = 20'd8;
            5'd7:    f = 20'd13;
            5'd8:    f = 20'd21;
            5'd9:    f = 20'd34;
            5'd10:   f = 20'd55;
            5'd11:   f = 20'd89;
            5'd12:   f = 20'd144;
            5'd13:   f = 20'd233;
            5'd14:   f = 20'd377;
            5'd15:   f = 20'd610;
            5'd16:   f = 20'd987;
            5'd17:   f = 20'd1597;
            5'd18:   f = 20'd2584;
            5'd19:   f = 20'd4181;
            5'd20:   f = 20'd6765;
            5'd21:   f = 20'd10946;
            5'd22:   f = 20'd17711;
            5'd23:   f = 20'd28657;
            5'd24:   f = 20'd46368;
            5'd25:   f = 20'd75025;
            5'd26:   f = 20'd121393;
            5'd27:   f = 20'd196418;
            5'd28:   f = 20'd317811;
            5'd29:   f = 20'd514229;
            5'd30:   f = 20'd832040;
            default: f = 20'd0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ifns_digit_stage.sv
// ifns_digit_stage: one combinational IFNS digit decision plus the remainder
// update; top_mode selects the plain greedy rule used for d29.
module ifns_digit_stage
    import ifns_pkg::*;
(
    input  logic [DATA_W-1:0] i_r,
    input  logic              i_d_prev,
    input  logic [DATA_W-1:0] i_weight,
    input  logic [DATA_W-1:0] i_upper,
    input  logic              i_top_mode,
    output logic              o_d,
    output logic [DATA_W-1:0] o_r_next
);

    // Digit rule: forced 1 at or above the next weight, forced 0 below its own
    // weight, otherwise repeat the digit above (keeps the codeword transition-safe).
    always_comb begin
        o_d = 1'b0;
        if (i_top_mode) begin
            o_d = (i_r >= i_weight);
        end else if (i_r >= i_upper) begin
            o_d = 1'b1;
        end else if (i_r < i_weight) begin
            o_d = 1'b0;
        end else begin
            o_d = i_d_prev;
        end
        o_r_next = o_d ? (i_r - i_weight) : i_r;
    end

endmodule

// File: rtl/ifns_enc_seq.sv
// ifns_enc_seq: sequential IFNS encoder, a shared digit stage walked over d29..d1.
// Defining IFNS_2DIGIT_EN chains two stages per cycle (latency 15 instead of 29).
module ifns_enc_seq
    import ifns_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              busy
);

`ifdef IFNS_2DIGIT_EN
    localparam logic [4:0] K_DEC  = 5'd2;
    localparam logic [4:0] K_LAST = 5'd3;
`else
    localparam logic [4:0] K_DEC  = 5'd1;
    localparam logic [4:0] K_LAST = 5'd2;
`endif

    state_e            r_state;
    state_e            w_state_nxt;
    logic [DATA_W-1:0] r_rem;
    logic [4:0]        r_k;
    logic [CODE_W-1:0] r_code;
    logic              r_out_valid;
    logic              r_busy;

    logic              w_top;
    logic [4:0]        w_k0;
    logic [DATA_W-1:0] w_weight0;
    logic [DATA_W-1:0] w_upper0;
    logic              w_d_prev0;
    logic              w_d0;
    logic [DATA_W-1:0] w_r0_next;
    logic [DATA_W-1:0] w_r_last;

    // In TOP the stage index 29 addresses d29, so index-1 is its codeword bit.
    assign w_top     = (r_state == TOP);
    assign w_k0      = w_top ? TOP_IDX : r_k;
    assign w_weight0 = w_top ? TOP_WEIGHT : fib(w_k0);
    assign w_upper0  = fib(w_k0 + 5'd1);
    assign w_d_prev0 = w_top ? 1'b0 : r_code[w_k0];

    ifns_digit_stage u_stage0 (
        .i_r        (r_rem),
        .i_d_prev   (w_d_prev0),
        .i_weight   (w_weight0),
        .i_upper    (w_upper0),
        .i_top_mode (w_top),
        .o_d        (w_d0),
        .o_r_next   (w_r0_next)
    );

`ifdef IFNS_2DIGIT_EN
    logic [4:0]        w_k1;
    logic              w_d1;
    logic [DATA_W-1:0] w_r1_next;

    assign w_k1 = w_k0 - 5'd1;

    ifns_digit_stage u_stage1 (
        .i_r        (w_r0_next),
        .i_d_prev   (w_d0),
        .i_weight   (fib(w_k1)),
        .i_upper    (fib(w_k0)),
        .i_top_mode (1'b0),
        .o_d        (w_d1),
        .o_r_next   (w_r1_next)
    );

    assign w_r_last = w_r1_next;
`else
    assign w_r_last = w_r0_next;
`endif

    // Next-state logic of the encode sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = TOP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            TOP:  w_state_nxt = STEP;
            STEP: begin
                if (r_k == K_LAST) begin
                    w_state_nxt = LAST;
                end else begin
                    w_state_nxt = STEP;
                end
            end
            LAST: w_state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and registered handshake/status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt == TOP) || (w_state_nxt == STEP);
        end
    end

    // Remainder, digit index and codeword accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= 20'd0;
            r_k    <= 5'd0;
            r_code <= 29'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_rem  <= in_data;
                        r_code <= 29'd0;
                    end
                end
                TOP, STEP: begin
                    r_rem                <= w_r_last;
                    r_code[w_k0 - 5'd1]  <= w_d0;
`ifdef IFNS_2DIGIT_EN
                    r_code[w_k0 - 5'd2]  <= w_d1;
`endif
                    r_k                  <= w_k0 - K_DEC;
                end
                LAST:    r_code[0] <= r_rem[0];
                default: r_rem     <= r_rem;
            endcase
        end
    end

    // in_ready must read 1 as soon as reset releases, before any clock edge.
    assign in_ready  = rst_n & (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign out_code  = r_code;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ifns_enc_seq.sv
// tb_ifns_enc_seq: directed and randomised checks of ifns_enc_seq against a
// cycle-level behavioural model of the IFNS digit rules and handshake timing.
module tb_ifns_enc_seq;

`ifdef IFNS_2DIGIT_EN
    localparam int LAT = 15;
`else
    localparam int LAT = 29;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [28:0] out_code;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int model_underflow = 0;
    int cyc = 0;
    int sent = 0;
    int delivered = 0;
    int sink_mode = 1;

    bit          have_word = 1'b0;
    int          e0 = 0;
    logic [28:0] exp_code = 29'd0;

    ifns_enc_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fibf(input int k);
        int a = 1;
        int b = 1;
        int t;
        for (int i = 3; i <= k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic logic [28:0] golden(input logic [19:0] v);
        int          r;
        logic [29:1] d;
        r = int'(v);
        d = '0;
        if (r >= 832040) begin
            d[29] = 1'b1;
            r -= 832040;
        end
        for (int k = 28; k >= 2; k--) begin
            if (r >= fibf(k + 1))  d[k] = 1'b1;
            else if (r < fibf(k))  d[k] = 1'b0;
            else                   d[k] = d[k + 1];
            if (d[k]) r -= fibf(k);
            if (r < 0) model_underflow++;
        end
        d[1] = r[0];
        return d;
    endfunction

    // Cycle-level model: latency, busy window, in_ready and the codeword.
    initial begin
        int el;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_flags", 32'({in_ready, out_valid, busy}), 32'd0);
                chk("rst_code", 32'(out_code), 32'd0);
                have_word = 1'b0;
            end else begin
                el = cyc - e0;
                chk("in_ready", 32'(in_ready), 32'(!have_word));
                chk("busy", 32'(busy), 32'(have_word && el <= LAT - 2));
                chk("out_valid", 32'(out_valid), 32'(have_word && el >= LAT));
                if (out_valid && have_word)
                    chk("out_code", 32'(out_code), 32'(exp_code));
                if (out_valid && out_ready && have_word) begin
                    have_word = 1'b0;
                    delivered++;
                end else if (in_valid && in_ready) begin
                    have_word = 1'b1;
                    e0 = cyc + 1;
                    exp_code = golden(in_data);
                end
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (sink_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input logic [19:0] v);
        int n = 0;
        bit hs = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #2;
            n++;
        end
        in_valid = 1'b0;
        if (hs) sent++;
        else chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((have_word || !in_ready) && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("idle_timeout", 32'(have_word || !in_ready), 32'd0);
    endtask

    task automatic send_expect(input string name, input logic [19:0] v, input logic [28:0] exp);
        send(v);
        wait_out({name, "_valid"});
        chk(name, 32'(out_code), 32'(exp));
        wait_idle();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 20'd0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_code", 32'(out_code), 32'd0);

        // Hand-derived codewords pin the model before it is trusted.
        chk("model_0", 32'(golden(20'd0)), 32'h0000000);
        chk("model_1", 32'(golden(20'd1)), 32'h0000001);
        chk("model_2", 32'(golden(20'd2)), 32'h0000003);
        chk("model_832040", 32'(golden(20'd832040)), 32'h10000000);
        chk("model_max", 32'(golden(20'd1048575)), 32'h1318F980);

        sink_mode = 1;
        send_expect("code_0", 20'd0, 29'h0000000);
        send_expect("code_1", 20'd1, 29'h0000001);
        send_expect("code_2", 20'd2, 29'h0000003);
        send_expect("code_832040", 20'd832040, 29'h10000000);
        send_expect("code_max", 20'd1048575, 29'h1318F980);
        send_expect("code_832039", 20'd832039, golden(20'd832039));
        send_expect("code_317811", 20'd317811, golden(20'd317811));

        sink_mode = 2;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #2;
            end
            send(20'($urandom_range(0, 1048575)));
        end
        wait_idle();

        // Back-pressure: codeword must hold while the sink stalls.
        sink_mode = 0;
        @(posedge clk);
        #3;
        send(20'd777);
        wait_out("hold_seen");
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_code", 32'(out_code), 32'(golden(20'd777)));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        sink_mode = 1;
        @(posedge clk);
        #3;
        @(posedge clk);
        #1;
        chk("release_idle", 32'(in_ready), 32'd1);
        chk("release_valid_low", 32'(out_valid), 32'd0);

        // Abort mid-encode at E12.
        send(20'd12345);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_flags", 32'({in_ready, out_valid, busy}), 32'd0);
        chk("abort_code", 32'(out_code), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("abort_release_ready", 32'(in_ready), 32'd1);
        repeat (40) @(posedge clk);
        #2;
        send_expect("post_abort", 20'd54321, golden(20'd54321));

        chk("word_count", 32'(delivered), 32'(sent - 1));
        chk("model_no_underflow", 32'(model_underflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
